// File: rtl/regfile_wb_arb.sv
// Register-file writeback controller: arbitrates ALU and load writebacks into an
// in-order FIFO and issues at most one register write per cycle, with a pending bitmap.
module regfile_wb_arb #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [AW-1:0]     alu_addr_i,
    input  logic [DW-1:0]     alu_data_i,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [AW-1:0]     ld_addr_i,
    input  logic [DW-1:0]     ld_data_i,
    output logic              wb_en_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_data_o,
    output logic [2**AW-1:0]  pend_o,
    output logic [AW:0]       count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       streak_q, streak_d;
    logic             wb_en_q, wb_en_d;
    logic [AW-1:0]    wb_addr_q, wb_addr_d;
    logic [DW-1:0]    wb_data_q, wb_data_d;

    logic             full;
    logic             empty;
    logic             streak_sat;
    logic             ld_acc;
    logic             alu_acc;
    logic             push;
    logic             pop;
    logic [AW-1:0]    push_addr;
    logic [DW-1:0]    push_data;
    logic [DEPTH-1:0] entry_valid;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign streak_sat = (streak_q == 2'd2);

    // Readies are forced low while reset is asserted, independent of the clock.
    assign ld_ready_o  = rst_ni & ~full & ~(streak_sat & alu_valid_i);
    assign alu_ready_o = rst_ni & ~full & (~ld_valid_i | streak_sat);

    assign ld_acc    = ld_valid_i & ld_ready_o;
    assign alu_acc   = alu_valid_i & alu_ready_o;
    assign push      = ld_acc | alu_acc;
    assign pop       = ~empty;
    assign push_addr = ld_acc ? ld_addr_i : alu_addr_i;
    assign push_data = ld_acc ? ld_data_i : alu_data_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        streak_d  = streak_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            wb_en_d   = 1'b1;
            wb_addr_d = addr_mem[rd_ptr_q];
            wb_data_d = data_mem[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Streak counts loads won while the ALU was waiting; at 2 the ALU gets a turn.
        if (alu_acc || !alu_valid_i) begin
            streak_d = 2'd0;
        end else if (ld_acc) begin
            streak_d = streak_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= push_addr;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            streak_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            streak_q  <= streak_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        logic [PW-1:0] offset;
        assign offset          = PW'(gi) - rd_ptr_q;
        assign entry_valid[gi] = (CW'(offset) < count_q);
    end

    always_comb begin
        pend_o = '0;
        if (wb_en_q) begin
            pend_o[wb_addr_q] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pend_o[addr_mem[i]] = 1'b1;
            end
        end
    end

    assign wb_en_o   = wb_en_q;
    assign wb_addr_o = wb_addr_q;
    assign wb_data_o = wb_data_q;
    assign count_o   = count_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: directed scenarios plus random traffic, all checked
// against a queue-based reference of the writeback path.
module tb_regfile_wb_arb;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 4;
    localparam int NR    = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, ld_valid;
    logic [AW-1:0] alu_addr, ld_addr;
    logic [DW-1:0] alu_data, ld_data;
    logic          alu_ready, ld_ready;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [NR-1:0] pend;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    regfile_wb_arb #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .alu_valid_i (alu_valid),
        .alu_ready_o (alu_ready),
        .alu_addr_i  (alu_addr),
        .alu_data_i  (alu_data),
        .ld_valid_i  (ld_valid),
        .ld_ready_o  (ld_ready),
        .ld_addr_i   (ld_addr),
        .ld_data_i   (ld_data),
        .wb_en_o     (wb_en),
        .wb_addr_o   (wb_addr),
        .wb_data_o   (wb_data),
        .pend_o      (pend),
        .count_o     (count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: queue of accepted writes plus the issued-write register.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           mq[$];
    int            m_streak;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          obs_ld_acc;

    function automatic void model_reset();
        mq.delete();
        m_streak = 0;
        m_en     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endfunction

    task automatic step(input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                        input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        logic          full, exp_lr, exp_ar, acc_l, acc_a;
        logic [NR-1:0] exp_pend;
        wr_t           e;
        @(negedge clk);
        ld_valid  = lv;  ld_addr  = la; ld_data  = ldd;
        alu_valid = av;  alu_addr = aa; alu_data = ad;
        #1;
        full   = (mq.size() == DEPTH);
        exp_lr = !full && !(m_streak == 2 && av);
        exp_ar = !full && (!lv || m_streak == 2);
        exp_pend = '0;
        foreach (mq[i]) exp_pend[mq[i].a] = 1'b1;
        if (m_en) exp_pend[m_addr] = 1'b1;
        chk("ld_ready",  {31'd0, ld_ready},  {31'd0, exp_lr});
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, exp_ar});
        chk("wb_en",     {31'd0, wb_en},     {31'd0, m_en});
        chk("wb_addr",   {29'd0, wb_addr},   {29'd0, m_addr});
        chk("wb_data",   {16'd0, wb_data},   {16'd0, m_data});
        chk("pend",      {24'd0, pend},      {24'd0, exp_pend});
        chk("count",     {28'd0, count},     mq.size());
        obs_ld_acc = lv & ld_ready;
        acc_l = lv && exp_lr;
        acc_a = av && exp_ar;
        @(posedge clk);
        if (mq.size() > 0) begin
            e      = mq.pop_front();
            m_en   = 1'b1;
            m_addr = e.a;
            m_data = e.d;
            $display("WB r%0d <= %h (t=%0t)", e.a, e.d, $time);
        end else begin
            m_en = 1'b0;
        end
        if (acc_l)      mq.push_back({la, ldd});
        else if (acc_a) mq.push_back({aa, ad});
        if (acc_a || !av) m_streak = 0;
        else if (acc_l)   m_streak = m_streak + 1;
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    logic [5:0] fair_pat;

    initial begin
        model_reset();
        fair_pat  = 6'b011011;
        rst_n     = 1'b0;
        ld_valid  = 1'b1; ld_addr  = 3'd1; ld_data  = 16'h1111;
        alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 16'h2222;

        // Reset held with both requesters active
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ld_ready",  {31'd0, ld_ready},  32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_wb_en",     {31'd0, wb_en},     32'd0);
        chk("rst_pend",      {24'd0, pend},      32'd0);
        chk("rst_count",     {28'd0, count},     32'd0);
        ld_valid = 1'b0; alu_valid = 1'b0;
        rst_n = 1'b1;
        $display("RESET released (t=%0t)", $time);

        // Single load r3 = BEEF, accepted on the first edge after release
        step(1'b1, 3'd3, 16'hBEEF, 1'b0, '0, '0);
        idle();
        chk("single_en",   {31'd0, wb_en},   32'd1);
        chk("single_addr", {29'd0, wb_addr}, 32'd3);
        chk("single_data", {16'd0, wb_data}, 32'hBEEF);
        chk("single_pend", {24'd0, pend},    32'h08);
        idle();
        chk("single_pend_clr", {24'd0, pend},  32'h00);
        chk("single_en_clr",   {31'd0, wb_en}, 32'd0);

        // Fairness: both requesters held high for six cycles
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 3'(k), 16'hA000 + 16'(k), 1'b1, 3'(7 - k), 16'hC000 + 16'(k));
            chk($sformatf("fair_%0d_ld", k), {31'd0, obs_ld_acc}, {31'd0, fair_pat[k]});
        end
        repeat (2) idle();

        // Load burst of DEPTH+2 writes, including r7
        for (int k = 0; k < DEPTH + 2; k++) begin
            step(1'b1, 3'(k + 2), 16'h5000 + 16'(k), 1'b0, '0, '0);
            chk("burst_count_max", {31'd0, (count <= DEPTH)}, 32'd1);
        end
        repeat (2) idle();

        // Same register written back to back: last one wins
        step(1'b0, '0, '0, 1'b1, 3'd5, 16'd1);
        step(1'b1, 3'd5, 16'd2, 1'b0, '0, '0);
        chk("same_data1", {16'd0, wb_data}, 32'd1);
        chk("same_pend1", {31'd0, pend[5]}, 32'd1);
        idle();
        chk("same_data2", {16'd0, wb_data}, 32'd2);
        chk("same_pend2", {31'd0, pend[5]}, 32'd1);
        idle();
        chk("same_pend3", {31'd0, pend[5]}, 32'd0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 16'($urandom));
        end

        // Asynchronous reset in the middle of a burst
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 3'(k), 16'h7700 + 16'(k), 1'b1, 3'(k + 4), 16'h8800 + 16'(k));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wb_en",   {31'd0, wb_en},     32'd0);
        chk("arst_wb_addr", {29'd0, wb_addr},   32'd0);
        chk("arst_wb_data", {16'd0, wb_data},   32'd0);
        chk("arst_pend",    {24'd0, pend},      32'd0);
        chk("arst_count",   {28'd0, count},     32'd0);
        chk("arst_ld_rdy",  {31'd0, ld_ready},  32'd0);
        chk("arst_alu_rdy", {31'd0, alu_ready}, 32'd0);
        ld_valid = 1'b0; alu_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        $display("RESET released (t=%0t)", $time);
        repeat (3) idle();
        step(1'b1, 3'd6, 16'h1234, 1'b0, '0, '0);
        idle();
        chk("post_rst_en",   {31'd0, wb_en},   32'd1);
        chk("post_rst_data", {16'd0, wb_data}, 32'h1234);
        repeat (2) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
